// File: rtl/move_if.sv
// Column/drop request and detector feedback bundle between the move
// controller (slave) and its environment (master).
interface move_if;
  logic [1:0]  col_sel;
  logic        drop;
  logic [1:0]  game_status;
  logic [15:0] game_board;
  logic [15:0] player_cells;
  logic        current_player;
  logic [4:0]  move_count;
  logic        busy;
  logic        invalid_move;
  logic        game_over;

  modport master (
    output col_sel, drop, game_status,
    input  game_board, player_cells, current_player, move_count,
           busy, invalid_move, game_over
  );

  modport slave (
    input  col_sel, drop, game_status,
    output game_board, player_cells, current_player, move_count,
           busy, invalid_move, game_over
  );
endinterface

// File: rtl/move_controller.sv
// Connect-4 (4x4) move sequencer: gravity drop, player alternation and
// freeze on a win/tie reported by the downstream detector.
//
// state  | meaning
// IDLE   | waiting for a drop rising edge
// SCAN   | probing heights bottom-up for the first empty cell
// PLACE  | writing the piece into board and owner vectors
// SETTLE | one cycle for the detector to see the new board
// CHECK  | sample game_status; freeze or hand over the turn
// OVER   | game finished, only reset leaves
module move_controller #(
  parameter logic FIRST_PLAYER = 1'b0,
  parameter int   MAX_MOVES    = 16
) (
  input logic  clk,
  input logic  reset,
  move_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SCAN, PLACE, SETTLE, CHECK, OVER} state_t;

  localparam logic [4:0] CNT_MAX = 5'(MAX_MOVES);

  state_t      state_q, state_d;
  logic [1:0]  col_q, col_d;
  logic [1:0]  h_q, h_d;
  logic [15:0] board_q, board_d;
  logic [15:0] cells_q, cells_d;
  logic        player_q, player_d;
  logic [4:0]  count_q, count_d;
  logic        invalid_q, invalid_d;
  logic        drop_q;
  logic        busy_q;
  logic        over_q;
  logic        drop_edge;
  logic [3:0]  idx;

  assign drop_edge = bus.drop & ~drop_q;
  // height h in column c lives at bit 4*h + c
  assign idx = {h_q, col_q};

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    h_d       = h_q;
    board_d   = board_q;
    cells_d   = cells_q;
    player_d  = player_q;
    count_d   = count_q;
    invalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (drop_edge) begin
          col_d   = bus.col_sel;
          h_d     = 2'd0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!board_q[idx]) begin
          state_d = PLACE;
        end else if (h_q == 2'd3) begin
          invalid_d = 1'b1;
          state_d   = IDLE;
        end else begin
          h_d = h_q + 2'd1;
        end
      end
      PLACE: begin
        board_d[idx] = 1'b1;
        cells_d[idx] = player_q;
        count_d      = (count_q == CNT_MAX) ? count_q : count_q + 5'd1;
        state_d      = SETTLE;
      end
      SETTLE: state_d = CHECK;
      CHECK: begin
        if (bus.game_status != 2'b00) begin
          state_d = OVER;
        end else begin
          player_d = ~player_q;
          state_d  = IDLE;
        end
      end
      OVER:    state_d = OVER;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      col_q     <= 2'd0;
      h_q       <= 2'd0;
      board_q   <= '0;
      cells_q   <= '0;
      player_q  <= FIRST_PLAYER;
      count_q   <= '0;
      invalid_q <= 1'b0;
      drop_q    <= 1'b0;
      busy_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      h_q       <= h_d;
      board_q   <= board_d;
      cells_q   <= cells_d;
      player_q  <= player_d;
      count_q   <= count_d;
      invalid_q <= invalid_d;
      drop_q    <= bus.drop;
      busy_q    <= (state_d != IDLE);
      over_q    <= (state_d == OVER);
    end
  end

  assign bus.game_board     = board_q;
  assign bus.player_cells   = cells_q;
  assign bus.current_player = player_q;
  assign bus.move_count     = count_q;
  assign bus.busy           = busy_q;
  assign bus.invalid_move   = invalid_q;
  assign bus.game_over      = over_q;

endmodule
